letc_core_rf_wr_arb: RTL

Write-port arbiter for the LETC core integer register file. Shares the single rd write port of `letc_core_rf` between the in-order pipeline writeback (port 0, unbuffered, normally preferred) and the long-latency unit writeback (port 1, mul/div/late loads), which goes through a one-entry holding buffer. A starvation guard bounds port 1 wait time. The buffered destination is exported so decode can stall on hazards.

---
 rtl/letc_core_rf_wr_arb_pkg.sv | 32 +++
 rtl/letc_core_rf_wr_arb_if.sv | 50 +++++
 rtl/letc_core_rf_wr_arb.sv | 114 +++++++++++
 3 files changed

// File: rtl/letc_core_rf_wr_arb_pkg.sv
// ---------------------------------------------------------------------------
// letc_core_rf_wr_arb_pkg
//
// Shared types for the register-file write-port arbiter slice.
//   reg_idx_t    : architectural integer register index (x0..x31)
//   word_t       : integer register data word
//   rf_wr_req_s  : one pending register-file write {idx, val}
//   is_live_dest : true when a destination actually changes architectural
//                  state (anything except x0)
// ---------------------------------------------------------------------------
package letc_core_rf_wr_arb_pkg;

  localparam int XLEN  = 32;
  localparam int IDX_W = 5;
  localparam int NREGS = 1 << IDX_W;

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]  word_t;

  typedef struct packed {
    reg_idx_t idx;
    word_t    val;
  } rf_wr_req_s;

  localparam reg_idx_t REG_X0 = '0;

  // x0 is hardwired to zero: writes to it are accepted but never reach the RF.
  function automatic logic is_live_dest(input reg_idx_t idx);
    return idx != REG_X0;
  endfunction

endpackage

// File: rtl/letc_core_rf_wr_arb_if.sv
// ---------------------------------------------------------------------------
// letc_core_rf_wr_arb_if
//
// Bundle of all handshake and data signals around the RF write arbiter.
//   wb0_*  : in-order pipeline writeback (valid/ready/idx/val)
//   wb1_*  : long-latency unit writeback (valid/ready/idx/val)
//   rf_rd_*: single write port towards letc_core_rf (idx/val/we)
//   pend1_*: registered buffer occupancy, consumed by decode hazard logic
//
// Modports:
//   slave  : the arbiter (consumes requests, drives readies / RF / pend)
//   master : the surrounding core (drives requests, observes the rest)
// ---------------------------------------------------------------------------
interface letc_core_rf_wr_arb_if;
  import letc_core_rf_wr_arb_pkg::*;

  logic     wb0_valid;
  logic     wb0_ready;
  reg_idx_t wb0_idx;
  word_t    wb0_val;

  logic     wb1_valid;
  logic     wb1_ready;
  reg_idx_t wb1_idx;
  word_t    wb1_val;

  reg_idx_t rf_rd_idx;
  word_t    rf_rd_val;
  logic     rf_rd_we;

  logic     pend1_valid;
  reg_idx_t pend1_idx;

  modport slave (
    input  wb0_valid, wb0_idx, wb0_val,
    input  wb1_valid, wb1_idx, wb1_val,
    output wb0_ready, wb1_ready,
    output rf_rd_idx, rf_rd_val, rf_rd_we,
    output pend1_valid, pend1_idx
  );

  modport master (
    output wb0_valid, wb0_idx, wb0_val,
    output wb1_valid, wb1_idx, wb1_val,
    input  wb0_ready, wb1_ready,
    input  rf_rd_idx, rf_rd_val, rf_rd_we,
    input  pend1_valid, pend1_idx
  );

endinterface

// File: rtl/letc_core_rf_wr_arb.sv
// ---------------------------------------------------------------------------
// letc_core_rf_wr_arb
//
// Shares the single rd write port of letc_core_rf between:
//   port 0 - in-order pipeline writeback, unbuffered, normally preferred
//   port 1 - long-latency writeback (mul/div/late loads), via a one-entry
//            holding buffer
// A starvation counter lets an occupied buffer pre-empt port 0 after
// STARVE_LIMIT consecutive blocked cycles, costing port 0 one stall cycle.
//
// Parameters:
//   STARVE_LIMIT : blocked cycles before pre-emption, legal 1..15
// Ports:
//   clk  : core clock
//   rst  : synchronous, active-high reset
//   bus  : letc_core_rf_wr_arb_if.slave (both writeback ports, RF write
//          port, pend1_* hazard outputs)
// ---------------------------------------------------------------------------
module letc_core_rf_wr_arb
  import letc_core_rf_wr_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  letc_core_rf_wr_arb_if.slave  bus
);

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  // Holding buffer for port 1 and its wait counter. Only the valid bit and
  // the counter are reset; the payload is qualified by hold_valid.
  logic       hold_valid;
  rf_wr_req_s hold_req;
  logic [3:0] starve_cnt;

  logic preempt;
  logic p0_live;
  logic p0_wr;
  logic hold_drain;
  logic squash;
  logic hold_free;
  logic wb1_store;

  // Grant and handshake decisions, all combinational on current state.
  always_comb begin
    preempt    = hold_valid && (starve_cnt == LIMIT_C);
    p0_live    = bus.wb0_valid && is_live_dest(bus.wb0_idx);

    // Port 0 owns the RF write port unless the buffer is pre-empting.
    p0_wr      = !rst && !preempt && p0_live;

    // The buffer writes whenever port 0 is not writing a live register
    // (this covers pre-emption too, since pre-emption blocks p0_wr).
    hold_drain = !rst && hold_valid && !p0_wr;

    // Port 0 is program-order younger than the buffered result, so a
    // same-register write from port 0 makes the buffered value dead.
    squash     = p0_wr && hold_valid && (bus.wb0_idx == hold_req.idx);

    hold_free  = !hold_valid || hold_drain || squash;

    // x0 results are accepted but never occupy the buffer.
    wb1_store  = !rst && bus.wb1_valid && hold_free && is_live_dest(bus.wb1_idx);
  end

  // Output drive.
  always_comb begin
    bus.wb0_ready   = !rst && !preempt;
    bus.wb1_ready   = !rst && hold_free;

    bus.rf_rd_we    = 1'b0;
    bus.rf_rd_idx   = '0;
    bus.rf_rd_val   = '0;
    if (p0_wr) begin
      bus.rf_rd_we  = 1'b1;
      bus.rf_rd_idx = bus.wb0_idx;
      bus.rf_rd_val = bus.wb0_val;
    end else if (hold_drain) begin
      bus.rf_rd_we  = 1'b1;
      bus.rf_rd_idx = hold_req.idx;
      bus.rf_rd_val = hold_req.val;
    end

    // Registered contents only: a result arriving this cycle is not visible.
    bus.pend1_valid = hold_valid;
    bus.pend1_idx   = hold_valid ? hold_req.idx : '0;
  end

  // Buffer occupancy and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      starve_cnt <= '0;
    end else if (wb1_store) begin
      hold_valid <= 1'b1;
      starve_cnt <= '0;
    end else if (hold_drain || squash) begin
      hold_valid <= 1'b0;
      starve_cnt <= '0;
    end else if (hold_valid && (starve_cnt != LIMIT_C)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Buffer payload.
  always_ff @(posedge clk) begin
    if (wb1_store) begin
      hold_req.idx <= bus.wb1_idx;
      hold_req.val <= bus.wb1_val;
    end
  end

endmodule
